// File: rtl/psram_arbiter.sv
// Two-port 32-bit arbiter onto a 16-bit asynchronous PSRAM; each access is two timed halfword cycles.
// Define PSRAM_VGA_PRIO_EN to give port 1 fixed priority on ties instead of round robin.
module psram_arbiter #(
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned T_ACC  = 7,
  parameter int unsigned T_REC  = 1
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_be,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_be,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,
  output logic              PSRAM_CLK,
  output logic              PSRAM_ADV_N,
  output logic              PSRAM_CE_N,
  output logic              PSRAM_OE_N,
  output logic              PSRAM_WE_N,
  output logic              PSRAM_LB_N,
  output logic              PSRAM_UB_N,
  output logic [ADDR_W:0]   PSRAM_ADDR,
  output logic [15:0]       dq_o,
  output logic              dq_oe,
  input  logic [15:0]       dq_i
);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_REC1, S_HI, S_REC2, S_ACK} state_t;

  localparam logic [3:0] ACC_LAST = 4'(T_ACC - 1);
  localparam logic [3:0] REC_LAST = 4'(T_REC - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic              lb_n_q, lb_n_d, ub_n_q, ub_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic [15:0]       dq_o_q, dq_o_d;
  logic [ADDR_W:0]   paddr_q, paddr_d;
  logic              gnt;
  logic              half;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rbuf_d       = rbuf_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    gnt          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
`ifdef PSRAM_VGA_PRIO_EN
          gnt = m1_req;
`else
          gnt = (m0_req && m1_req) ? ~last_grant_q : m1_req;
`endif
          last_grant_d = gnt;
          we_d    = gnt ? m1_we    : m0_we;
          addr_d  = gnt ? m1_addr  : m0_addr;
          wdata_d = gnt ? m1_wdata : m0_wdata;
          be_d    = gnt ? m1_be    : m0_be;
          cnt_d   = '0;
          // Write halves with no byte enables are never driven onto the bus.
          if (!we_d || (be_d[1:0] != 2'b00))      state_d = S_LO;
          else if (be_d[3:2] != 2'b00)            state_d = S_HI;
          else                                    state_d = S_ACK;
        end
      end
      S_LO: begin
        if (cnt_q == ACC_LAST) begin
          if (!we_q) rbuf_d[15:0] = dq_i;
          cnt_d   = '0;
          state_d = (!we_q || (be_q[3:2] != 2'b00)) ? S_REC1 : S_REC2;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_REC1: begin
        if (cnt_q == REC_LAST) begin
          cnt_d   = '0;
          state_d = S_HI;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HI: begin
        if (cnt_q == ACC_LAST) begin
          if (!we_q) rbuf_d[31:16] = dq_i;
          cnt_d   = '0;
          state_d = S_REC2;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_REC2: begin
        if (cnt_q == REC_LAST) begin
          cnt_d   = '0;
          state_d = S_ACK;
          if (!we_q) begin
            if (last_grant_q) m1_rdata_d = rbuf_q;
            else              m0_rdata_d = rbuf_q;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pin values are registered, so they are derived from the state being entered.
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    dq_o_d   = dq_o_q;
    paddr_d  = paddr_q;
    half     = 1'b0;
    m0_ack_d = 1'b0;
    m1_ack_d = 1'b0;

    if (state_d == S_LO || state_d == S_HI) begin
      half    = (state_d == S_HI);
      ce_n_d  = 1'b0;
      paddr_d = {addr_d, half};
      if (we_d) begin
        dq_oe_d = 1'b1;
        dq_o_d  = half ? wdata_d[31:16] : wdata_d[15:0];
        lb_n_d  = half ? ~be_d[2] : ~be_d[0];
        ub_n_d  = half ? ~be_d[3] : ~be_d[1];
        we_n_d  = (cnt_d == ACC_LAST);
      end else begin
        oe_n_d = 1'b0;
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
    end

    if (state_d == S_ACK) begin
      m0_ack_d = ~last_grant_d;
      m1_ack_d = last_grant_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rbuf_q       <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      lb_n_q       <= 1'b1;
      ub_n_q       <= 1'b1;
      dq_oe_q      <= 1'b0;
      dq_o_q       <= '0;
      paddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rbuf_q       <= rbuf_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      lb_n_q       <= lb_n_d;
      ub_n_q       <= ub_n_d;
      dq_oe_q      <= dq_oe_d;
      dq_o_q       <= dq_o_d;
      paddr_q      <= paddr_d;
    end
  end

  assign m0_ack      = m0_ack_q;
  assign m1_ack      = m1_ack_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign PSRAM_CLK   = 1'b0;
  assign PSRAM_ADV_N = 1'b0;
  assign PSRAM_CE_N  = ce_n_q;
  assign PSRAM_OE_N  = oe_n_q;
  assign PSRAM_WE_N  = we_n_q;
  assign PSRAM_LB_N  = lb_n_q;
  assign PSRAM_UB_N  = ub_n_q;
  assign PSRAM_ADDR  = paddr_q;
  assign dq_o        = dq_o_q;
  assign dq_oe       = dq_oe_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: default timing instance with a PSRAM model, plus a T_ACC=3 instance.
module tb_psram_arbiter;
  localparam int unsigned AW = 22;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [3:0]    m0_be, m1_be;
  logic          m0_ack, m1_ack;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          psram_clk, adv_n, ce_n, oe_n, we_n, lb_n, ub_n, dq_oe;
  logic [AW:0]   paddr;
  logic [15:0]   dq_o, dq_i;

  logic          b_req, b_we;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_wdata, b_rdata, b1_rdata;
  logic [3:0]    b_be;
  logic          b_ack, b1_ack, b_clk, b_adv, b_ce_n, b_oe_n, b_we_n, b_lb_n, b_ub_n, b_dq_oe;
  logic [AW:0]   b_paddr;
  logic [15:0]   b_dq_o;

  psram_arbiter #(.ADDR_W(AW), .T_ACC(7), .T_REC(1)) u_dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .PSRAM_CLK(psram_clk), .PSRAM_ADV_N(adv_n), .PSRAM_CE_N(ce_n), .PSRAM_OE_N(oe_n),
    .PSRAM_WE_N(we_n), .PSRAM_LB_N(lb_n), .PSRAM_UB_N(ub_n), .PSRAM_ADDR(paddr),
    .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i)
  );

  psram_arbiter #(.ADDR_W(AW), .T_ACC(3), .T_REC(1)) u_dut3 (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .m0_req(b_req), .m0_we(b_we), .m0_addr(b_addr), .m0_wdata(b_wdata), .m0_be(b_be),
    .m0_ack(b_ack), .m0_rdata(b_rdata),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr('0), .m1_wdata('0), .m1_be(4'h0),
    .m1_ack(b1_ack), .m1_rdata(b1_rdata),
    .PSRAM_CLK(b_clk), .PSRAM_ADV_N(b_adv), .PSRAM_CE_N(b_ce_n), .PSRAM_OE_N(b_oe_n),
    .PSRAM_WE_N(b_we_n), .PSRAM_LB_N(b_lb_n), .PSRAM_UB_N(b_ub_n), .PSRAM_ADDR(b_paddr),
    .dq_o(b_dq_o), .dq_oe(b_dq_oe), .dq_i(16'h0000)
  );

  // Halfword PSRAM model with byte lanes.
  logic [15:0] mem [0:63];
  assign dq_i = mem[paddr[5:0]];
  always @(posedge clk_sys) begin
    if (!ce_n && !we_n && dq_oe) begin
      if (!lb_n) mem[paddr[5:0]][7:0]  <= dq_o[7:0];
      if (!ub_n) mem[paddr[5:0]][15:8] <= dq_o[15:8];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]  tr_str  [0:31];
  logic        tr_oe   [0:31];
  logic [AW:0] tr_addr [0:31];
  logic [15:0] tr_dq   [0:31];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic access(input string tag, input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int exp_lat,
                        output logic [31:0] rdata);
    int lat;
    bit done;
    lat = 0;
    done = 1'b0;
    rdata = '0;
    if (port) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    end
    for (int i = 1; i <= 64 && !done; i++) begin
      tick();
      if (i < 32) begin
        tr_str[i]  = {ce_n, oe_n, we_n, lb_n, ub_n};
        tr_oe[i]   = dq_oe;
        tr_addr[i] = paddr;
        tr_dq[i]   = dq_o;
      end
      if (port ? m1_ack : m0_ack) begin
        lat = i;
        done = 1'b1;
        rdata = port ? m1_rdata : m0_rdata;
      end
    end
    check_val({tag, "_lat"}, lat, exp_lat);
    tick();
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  logic [31:0] rd;
  int          n_ack, acks, b_lat;
  bit          ack_port [0:3];
  int          ack_cyc  [0:3];
  logic [31:0] ack_data [0:3];
  logic [7:0]  we_vec, ce_vec, oe_vec;
  logic [15:0] b_lo_dq, b_hi_dq;
  logic [AW:0] b_hi_addr;
  logic [1:0]  b_lanes;
  bit          b_oe_low;
  bit          exp_port;

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    for (int k = 0; k < 4; k++) begin
      ack_port[k] = 1'b0; ack_cyc[k] = 0; ack_data[k] = '0;
    end
    repeat (3) tick();

    check_val("rst_strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1F);
    check_val("rst_dq", 32'({dq_oe, dq_o}), 32'h0);
    check_val("rst_addr", 32'(paddr), 32'h0);
    check_val("rst_acks", 32'({m0_ack, m1_ack}), 32'h0);
    check_val("rst_rdata0", m0_rdata, 32'h0);
    check_val("rst_rdata1", m1_rdata, 32'h0);
    check_val("rst_tied", 32'({psram_clk, adv_n}), 32'h0);
    rst_n = 1'b1;
    tick();

    access("wr_full", 1'b0, 1'b1, 22'h10, 32'hDEADBEEF, 4'hF, 17, rd);
    check_val("wr_lo_addr", 32'(tr_addr[1]), 32'h20);
    check_val("wr_lo_dq", 32'(tr_dq[1]), 32'hBEEF);
    check_val("wr_lo_strb", 32'(tr_str[1]), 32'h08);
    check_val("wr_lo_hold", 32'({tr_str[7], tr_oe[7]}), 32'h19);
    check_val("wr_rec1", 32'({tr_str[8], tr_oe[8]}), 32'h3E);
    check_val("wr_hi_addr", 32'(tr_addr[9]), 32'h21);
    check_val("wr_hi_dq", 32'(tr_dq[9]), 32'hDEAD);

    access("rd_full", 1'b0, 1'b0, 22'h10, 32'h0, 4'hF, 17, rd);
    check_val("rd_full_data", rd, 32'hDEADBEEF);
    check_val("rd_strb", 32'({tr_str[1], tr_oe[1]}), 32'h08);

    access("wr_lo_only", 1'b0, 1'b1, 22'h11, 32'h0000AAAA, 4'h3, 9, rd);
    check_val("wr_lo_only_addr", 32'(tr_addr[1]), 32'h22);
    access("wr_hi_only", 1'b0, 1'b1, 22'h11, 32'h12345678, 4'hC, 9, rd);
    check_val("wr_hi_only_addr", 32'(tr_addr[1]), 32'h23);
    check_val("wr_hi_only_dq", 32'(tr_dq[1]), 32'h1234);
    check_val("wr_hi_only_strb", 32'(tr_str[1]), 32'h08);
    access("rd_merge", 1'b0, 1'b0, 22'h11, 32'h0, 4'hF, 17, rd);
    check_val("rd_merge_data", rd, 32'h1234AAAA);

    access("wr_base", 1'b0, 1'b1, 22'h12, 32'h66665555, 4'hF, 17, rd);
    access("wr_byte1", 1'b0, 1'b1, 22'h12, 32'h0000AB00, 4'h2, 9, rd);
    check_val("wr_byte1_strb", 32'(tr_str[1]), 32'h0A);
    access("rd_m1", 1'b1, 1'b0, 22'h12, 32'h0, 4'hF, 17, rd);
    check_val("rd_m1_data", rd, 32'h6666AB55);
    check_val("m0_rdata_hold", m0_rdata, 32'h1234AAAA);
    access("wr_be0", 1'b0, 1'b1, 22'h13, 32'hFFFFFFFF, 4'h0, 1, rd);
    check_val("wr_be0_strb", 32'({tr_str[1], tr_oe[1]}), 32'h3E);

    // Reset during the HI phase of a write.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 22'h14; m0_wdata = 32'h11112222; m0_be = 4'hF;
    repeat (10) tick();
    check_val("abort_pre", 32'({ce_n, we_n, dq_oe}), 32'h1);
    rst_n = 1'b0;
    m0_req = 1'b0;
    tick();
    check_val("abort_strobes", 32'({ce_n, we_n, dq_oe, m0_ack}), 32'hC);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m0_ack || m1_ack) acks++;
    end
    check_val("abort_no_ack", acks, 0);
    access("rd_after_rst", 1'b1, 1'b0, 22'h10, 32'h0, 4'hF, 17, rd);
    check_val("rd_after_rst_data", rd, 32'hDEADBEEF);

    // Both ports reading continuously.
    m0_we = 1'b0; m0_addr = 22'h10; m0_be = 4'hF;
    m1_we = 1'b0; m1_addr = 22'h11; m1_be = 4'hF;
    m0_req = 1'b1; m1_req = 1'b1;
    n_ack = 0;
    for (int i = 1; i <= 120 && n_ack < 4; i++) begin
      tick();
      if (m0_ack || m1_ack) begin
        ack_port[n_ack] = m1_ack;
        ack_cyc[n_ack]  = i;
        ack_data[n_ack] = m1_ack ? m1_rdata : m0_rdata;
        n_ack++;
      end
    end
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    check_val("rr_n_ack", n_ack, 4);
    for (int k = 0; k < 4; k++) begin
`ifdef PSRAM_VGA_PRIO_EN
      exp_port = 1'b1;
`else
      exp_port = (k % 2) == 1;
`endif
      check_val($sformatf("rr_port%0d", k), 32'(ack_port[k]), 32'(exp_port));
      check_val($sformatf("rr_cyc%0d", k), ack_cyc[k], 17 + 18 * k);
      check_val($sformatf("rr_data%0d", k), ack_data[k], exp_port ? 32'h1234AAAA : 32'hDEADBEEF);
    end

    // Short-timing instance: WE_N hold cycle and recovery width.
    b_req = 1'b1; b_we = 1'b1; b_addr = 22'h1; b_wdata = 32'hCAFEF00D; b_be = 4'hF;
    b_lat = 0; we_vec = '0; ce_vec = '0; oe_vec = '0; b_oe_low = 1'b0;
    b_lo_dq = '0; b_hi_dq = '0; b_hi_addr = '0; b_lanes = '1;
    for (int i = 1; i <= 40 && b_lat == 0; i++) begin
      tick();
      if (i <= 8) begin
        we_vec[i-1] = b_we_n;
        ce_vec[i-1] = b_ce_n;
        oe_vec[i-1] = b_dq_oe;
      end
      if (!b_oe_n) b_oe_low = 1'b1;
      if (i == 1) begin
        b_lo_dq = b_dq_o;
        b_lanes = {b_lb_n, b_ub_n};
      end
      if (i == 5) begin
        b_hi_dq = b_dq_o;
        b_hi_addr = b_paddr;
      end
      if (b_ack) b_lat = i;
    end
    tick();
    b_req = 1'b0;
    check_val("t3_lat", b_lat, 9);
    check_val("t3_we_n", 32'(we_vec), 32'hCC);
    check_val("t3_ce_n", 32'(ce_vec), 32'h88);
    check_val("t3_dq_oe", 32'(oe_vec), 32'h77);
    check_val("t3_lo_dq", 32'(b_lo_dq), 32'hF00D);
    check_val("t3_hi_dq", 32'(b_hi_dq), 32'hCAFE);
    check_val("t3_hi_addr", 32'(b_hi_addr), 32'h3);
    check_val("t3_lanes", 32'(b_lanes), 32'h0);
    check_val("t3_oe_never", 32'(b_oe_low), 32'h0);
    check_val("t3_quiet", 32'({b_rdata, b1_rdata, b1_ack, b_clk, b_adv} != '0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
